// File: rtl/pipeline_ex_mem_reg_if.sv
// EX/MEM bundle: E-stage fields driven by execute, M-stage fields driven by the pipeline register.
interface pipeline_ex_mem_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MEMTYPE_W  = 2
);
    logic                  ValidE;
    logic                  MemReadE;
    logic                  MemToRegE;
    logic                  MemWriteE;
    logic                  RegWriteE;
    logic [DATA_W-1:0]     ALUresultE;
    logic [DATA_W-1:0]     ReadData2E;
    logic [REG_ADDR_W-1:0] WriteRegE;
    logic [MEMTYPE_W-1:0]  MemTypeE;
    logic [DATA_W-1:0]     PCPlus4E;

    logic                  ValidM;
    logic                  MemReadM;
    logic                  MemToRegM;
    logic                  MemWriteM;
    logic                  RegWriteM;
    logic [DATA_W-1:0]     ALUresultM;
    logic [DATA_W-1:0]     ReadData2M;
    logic [REG_ADDR_W-1:0] WriteRegM;
    logic [MEMTYPE_W-1:0]  MemTypeM;
    logic [DATA_W-1:0]     PCPlus4M;

    modport master (
        output ValidE, MemReadE, MemToRegE, MemWriteE, RegWriteE,
               ALUresultE, ReadData2E, WriteRegE, MemTypeE, PCPlus4E,
        input  ValidM, MemReadM, MemToRegM, MemWriteM, RegWriteM,
               ALUresultM, ReadData2M, WriteRegM, MemTypeM, PCPlus4M
    );

    modport slave (
        input  ValidE, MemReadE, MemToRegE, MemWriteE, RegWriteE,
               ALUresultE, ReadData2E, WriteRegE, MemTypeE, PCPlus4E,
        output ValidM, MemReadM, MemToRegM, MemWriteM, RegWriteM,
               ALUresultM, ReadData2M, WriteRegM, MemTypeM, PCPlus4M
    );
endinterface

// File: rtl/pipeline_ex_mem_reg.sv
// EX/MEM pipeline register with valid tracking, stall hold and flush bubble insertion.
// Define PIPE_PERF_CNT_EN to add saturating stall/flush performance counters.
module pipeline_ex_mem_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MEMTYPE_W  = 2
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 StallM,
    input  logic                 FlushM,
    pipeline_ex_mem_reg_if.slave bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     StallCntM,
    output logic [CNT_W-1:0]     FlushCntM
`endif
);

    typedef struct packed {
        logic                  valid;
        logic                  memRead;
        logic                  memToReg;
        logic                  memWrite;
        logic                  regWrite;
        logic [DATA_W-1:0]     aluResult;
        logic [DATA_W-1:0]     readData2;
        logic [REG_ADDR_W-1:0] writeReg;
        logic [MEMTYPE_W-1:0]  memType;
        logic [DATA_W-1:0]     pcPlus4;
    } stageM_t;

    stageM_t mReg;
    stageM_t mNext;

    always_comb begin
        // NOTE: hold is the default so every path assigns mNext and no latch is inferred.
        mNext = mReg;
        if (FlushM) begin
            mNext = '0;
        end else if (!StallM) begin
            // Side-effect controls of a bubble are forced off; data fields are don't-care.
            mNext.valid     = bus.ValidE;
            mNext.memRead   = bus.ValidE & bus.MemReadE;
            mNext.memToReg  = bus.MemToRegE;
            mNext.memWrite  = bus.ValidE & bus.MemWriteE;
            mNext.regWrite  = bus.ValidE & bus.RegWriteE;
            mNext.aluResult = bus.ALUresultE;
            mNext.readData2 = bus.ReadData2E;
            mNext.writeReg  = bus.WriteRegE;
            mNext.memType   = bus.MemTypeE;
            mNext.pcPlus4   = bus.PCPlus4E;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge Clk) begin
        if (!Rst_n) mReg <= '0;
        else        mReg <= mNext;
    end

    assign bus.ValidM     = mReg.valid;
    assign bus.MemReadM   = mReg.memRead;
    assign bus.MemToRegM  = mReg.memToReg;
    assign bus.MemWriteM  = mReg.memWrite;
    assign bus.RegWriteM  = mReg.regWrite;
    assign bus.ALUresultM = mReg.aluResult;
    assign bus.ReadData2M = mReg.readData2;
    assign bus.WriteRegM  = mReg.writeReg;
    assign bus.MemTypeM   = mReg.memType;
    assign bus.PCPlus4M   = mReg.pcPlus4;

`ifdef PIPE_PERF_CNT_EN
    // Counters stop at all-ones rather than wrapping.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            StallCntM <= '0;
            FlushCntM <= '0;
        end else begin
            if (FlushM && (FlushCntM != '1))
                FlushCntM <= FlushCntM + CNT_W'(1);
            if (StallM && !FlushM && (StallCntM != '1))
                StallCntM <= StallCntM + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ex_mem_reg.sv
// Randomized bench for pipeline_ex_mem_reg against a rule-level reference model.
module tb_pipeline_ex_mem_reg;

    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic Clk = 1'b0;
    logic Rst_n;
    logic StallM;
    logic FlushM;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] StallCntM;
    logic [CNT_W-1:0] FlushCntM;
`endif

    int totalCnt = 0;
    int badCnt   = 0;

    typedef struct packed {
        logic        valid;
        logic        memRead;
        logic        memToReg;
        logic        memWrite;
        logic        regWrite;
        logic [31:0] aluResult;
        logic [31:0] readData2;
        logic [4:0]  writeReg;
        logic [1:0]  memType;
        logic [31:0] pcPlus4;
    } expM_t;

    expM_t mdl;
    int    mdlStallCnt;
    int    mdlFlushCnt;

    pipeline_ex_mem_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .MEMTYPE_W(2)) bus ();

    pipeline_ex_mem_reg #(
        .DATA_W(32), .REG_ADDR_W(5), .MEMTYPE_W(2)
`ifdef PIPE_PERF_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .StallM(StallM),
        .FlushM(FlushM),
        .bus   (bus.slave)
`ifdef PIPE_PERF_CNT_EN
        , .StallCntM(StallCntM)
        , .FlushCntM(FlushCntM)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        totalCnt++;
        if (got !== want) begin
            badCnt++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic setE(input logic v, input logic mr, input logic mtr, input logic mw,
                        input logic rw, input logic [31:0] alu, input logic [31:0] rd2,
                        input logic [4:0] wreg, input logic [1:0] mt, input logic [31:0] pc4);
        bus.ValidE     = v;
        bus.MemReadE   = mr;
        bus.MemToRegE  = mtr;
        bus.MemWriteE  = mw;
        bus.RegWriteE  = rw;
        bus.ALUresultE = alu;
        bus.ReadData2E = rd2;
        bus.WriteRegE  = wreg;
        bus.MemTypeE   = mt;
        bus.PCPlus4E   = pc4;
    endtask

    // Reference: what the M stage should hold after one edge, from the priority rules.
    task automatic modelEdge();
        if (!Rst_n) begin
            mdl = '0;
            mdlStallCnt = 0;
            mdlFlushCnt = 0;
        end else if (FlushM) begin
            mdl = '0;
            if (mdlFlushCnt < CMAX) mdlFlushCnt++;
        end else if (StallM) begin
            if (mdlStallCnt < CMAX) mdlStallCnt++;
        end else begin
            mdl.valid     = bus.ValidE;
            mdl.memRead   = bus.ValidE ? bus.MemReadE  : 1'b0;
            mdl.memWrite  = bus.ValidE ? bus.MemWriteE : 1'b0;
            mdl.regWrite  = bus.ValidE ? bus.RegWriteE : 1'b0;
            mdl.memToReg  = bus.MemToRegE;
            mdl.aluResult = bus.ALUresultE;
            mdl.readData2 = bus.ReadData2E;
            mdl.writeReg  = bus.WriteRegE;
            mdl.memType   = bus.MemTypeE;
            mdl.pcPlus4   = bus.PCPlus4E;
        end
    endtask

    task automatic checkAll();
        check("ValidM",     32'(bus.ValidM),     32'(mdl.valid));
        check("MemReadM",   32'(bus.MemReadM),   32'(mdl.memRead));
        check("MemToRegM",  32'(bus.MemToRegM),  32'(mdl.memToReg));
        check("MemWriteM",  32'(bus.MemWriteM),  32'(mdl.memWrite));
        check("RegWriteM",  32'(bus.RegWriteM),  32'(mdl.regWrite));
        check("ALUresultM", bus.ALUresultM,      mdl.aluResult);
        check("ReadData2M", bus.ReadData2M,      mdl.readData2);
        check("WriteRegM",  32'(bus.WriteRegM),  32'(mdl.writeReg));
        check("MemTypeM",   32'(bus.MemTypeM),   32'(mdl.memType));
        check("PCPlus4M",   bus.PCPlus4M,        mdl.pcPlus4);
        check("bubbleInv",  32'({bus.MemReadM, bus.MemWriteM, bus.RegWriteM} & {3{~bus.ValidM}}), 32'd0);
`ifdef PIPE_PERF_CNT_EN
        check("StallCntM",  32'(StallCntM),      32'(mdlStallCnt));
        check("FlushCntM",  32'(FlushCntM),      32'(mdlFlushCnt));
`endif
    endtask

    // Apply controls, take one rising edge, then compare away from the edge.
    task automatic step(input logic rst, input logic stall, input logic flush);
        Rst_n  = rst;
        StallM = stall;
        FlushM = flush;
        @(posedge Clk);
        #1;
        modelEdge();
        checkAll();
    endtask

    initial begin
        mdl = '0;
        mdlStallCnt = 0;
        mdlFlushCnt = 0;
        setE(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0, 5'd9, 2'd0, 32'h0);
        @(negedge Clk);

        // Reset then load
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("rstValid", 32'(bus.ValidM), 32'd0);
        check("rstAlu",   bus.ALUresultM,  32'd0);
        step(1'b1, 1'b0, 1'b0);
        check("loadAlu",  bus.ALUresultM,     32'h0000_1234);
        check("loadWreg", 32'(bus.WriteRegM), 32'd9);
        check("loadRegW", 32'(bus.RegWriteM), 32'd1);
        check("loadVal",  32'(bus.ValidM),    32'd1);

        // Stall hold
        setE(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hAAAA_0001, 32'h11, 5'd3, 2'd2, 32'h10);
        step(1'b1, 1'b0, 1'b0);
        bus.ALUresultE = 32'h5555_0002;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0);
            check("stallHold", bus.ALUresultM, 32'hAAAA_0001);
        end
        step(1'b1, 1'b0, 1'b0);
        check("stallRelease", bus.ALUresultM, 32'h5555_0002);

        // Flush over stall, with MemWriteM = 1 beforehand
        check("preFlushMw", 32'(bus.MemWriteM), 32'd1);
        step(1'b1, 1'b1, 1'b1);
        check("flushMw",  32'(bus.MemWriteM), 32'd0);
        check("flushVal", 32'(bus.ValidM),    32'd0);
        check("flushAlu", bus.ALUresultM,     32'd0);

        // Bubble gating
        setE(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h22, 5'd7, 2'd1, 32'h20);
        step(1'b1, 1'b0, 1'b0);
        check("bubVal", 32'(bus.ValidM),    32'd0);
        check("bubMw",  32'(bus.MemWriteM), 32'd0);
        check("bubRw",  32'(bus.RegWriteM), 32'd0);
        check("bubAlu", bus.ALUresultM,     32'hDEAD_BEEF);

        // Reset mid-stall
        setE(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3, 32'h4, 5'd1, 2'd2, 32'h40);
        step(1'b1, 1'b0, 1'b0);
        check("preRstPc", bus.PCPlus4M, 32'h40);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("rstStallPc",  bus.PCPlus4M,     32'd0);
        check("rstStallVal", 32'(bus.ValidM),  32'd0);

`ifdef PIPE_PERF_CNT_EN
        // Counter saturation at CNT_W = 2
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1);
        check("stallSat", 32'(StallCntM), 32'd3);
        check("flushCnt", 32'(FlushCntM), 32'd2);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            setE(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom, $urandom, 5'($urandom), 2'($urandom), $urandom);
            step(($urandom_range(0, 99) >= 3) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 25)  ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 10)  ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule

// File: doc/pipeline_ex_mem_reg.md
Name: pipeline_ex_mem_reg

Overview:
- Parametrised EX/MEM pipeline register, the next generation of the fixed-width execute-to-memory latch.
- Adds a synchronous active-low reset, per-stage valid tracking, stall (hold), and flush (bubble insert).
- Sits between the ALU/forwarding logic and the data-memory stage; driven by the hazard unit.

Parameters:
- DATA_W, 32, width of ALU result, store data and PC+4 fields
- REG_ADDR_W, 5, width of destination register index
- MEMTYPE_W, 2, width of memory access-type code (byte/half/word)
- CNT_W, 16, width of performance counters (used only with PIPE_PERF_CNT_EN)

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Rst_n  in  1  synchronous active-low reset, sampled on rising edge of Clk
- StallM  in  1  hold current M-stage contents
- FlushM  in  1  load a bubble into M stage
- ValidE  in  1  E-stage instruction is real, not a bubble
- MemReadE, MemToRegE, MemWriteE, RegWriteE  in  1 each  E-stage control
- ALUresultE  in  DATA_W  ALU output
- ReadData2E  in  DATA_W  store data, post-forwarding
- WriteRegE  in  REG_ADDR_W  destination register
- MemTypeE  in  MEMTYPE_W  access type
- PCPlus4E  in  DATA_W  link address
- ValidM  out  1  M-stage instruction is real
- MemReadM, MemToRegM, MemWriteM, RegWriteM  out  1 each  registered control
- ALUresultM, ReadData2M, PCPlus4M  out  DATA_W  registered data
- WriteRegM  out  REG_ADDR_W  registered destination
- MemTypeM  out  MEMTYPE_W  registered access type
- StallCntM, FlushCntM  out  CNT_W each  performance counters (present only with PIPE_PERF_CNT_EN)

Behaviour:
- Latency: 1 cycle, E inputs appear on M outputs after the next rising edge of Clk.
- Priority per edge: Rst_n low > FlushM > StallM > normal load.
- Reset (Rst_n = 0 at edge): every output, including counters, goes to 0. A reset mid-stall or mid-flush discards held contents. The first load happens on the first edge with Rst_n = 1.
- Flush (FlushM = 1): ValidM, MemReadM, MemToRegM, MemWriteM, RegWriteM all load 0. All data fields load 0. Flush overrides a simultaneous StallM.
- Stall (StallM = 1, FlushM = 0): every output holds its previous value, and E inputs are ignored.
- Normal: every output loads the corresponding E input; ValidM loads ValidE.
- Bubble gating on load: if ValidE = 0, MemReadM, MemWriteM and RegWriteM load 0 regardless of their inputs. Data fields still load, since they are don't-care.
- Invariant: ValidM = 0 implies MemReadM = MemWriteM = RegWriteM = 0 at every cycle.
- No combinational path from any input to any output.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - StallCntM increments by 1 on each edge with Rst_n = 1, StallM = 1 and FlushM = 0.
  - FlushCntM increments by 1 on each edge with Rst_n = 1 and FlushM = 1.
  - Both counters saturate at all-ones and never wrap.
  - Both counters clear on reset.
- Not defined: the counter ports and logic are absent, and the rest of the behaviour is identical.

Test Plan:
- Reset then load: Rst_n = 0 for 2 cycles, then 1. Drive ValidE = 1, RegWriteE = 1, ALUresultE = 0x0000_1234, WriteRegE = 5'd9 -> all outputs 0 during reset; one edge after release, ALUresultM = 0x1234, WriteRegM = 9, RegWriteM = 1, ValidM = 1.
- Stall hold: load ALUresultE = 0xAAAA_0001, then StallM = 1 for 3 cycles while ALUresultE = 0x5555_0002 -> ALUresultM stays 0xAAAA_0001 for 3 cycles; 0x5555_0002 appears one edge after StallM drops.
- Flush over stall: StallM = 1 and FlushM = 1 on the same edge, with MemWriteM = 1 beforehand -> next cycle MemWriteM = 0, ValidM = 0, ALUresultM = 0.
- Bubble gating: ValidE = 0, MemWriteE = 1, RegWriteE = 1, ALUresultE = 0xDEAD_BEEF -> ValidM = 0, MemWriteM = 0, RegWriteM = 0 after one edge.
- Reset mid-stall: StallM = 1 holding PCPlus4M = 0x40, then Rst_n = 0 for one edge -> PCPlus4M = 0 and ValidM = 0 on that edge.
- PIPE_PERF_CNT_EN with CNT_W = 2: apply 5 stall edges and 2 flush edges -> StallCntM = 3 (saturated), FlushCntM = 2.
